// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multicycle RV32I core: sequences the shared memory port,
// ALU and register file over several cycles and drives the datapath selects and enables.
module multicycle_control_fsm #(
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [1:0] imm_src,
  output logic       illegal,
  output logic [3:0] state_o
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd15
  } state_e;

  state_e     state_q, state_d;
  logic       illegal_q, illegal_d;
  logic       memDone;
  logic       pcUpdate;
  logic       branch;
  logic [2:0] functAlu;

  // Without the handshake every memory access is assumed to finish in one cycle.
  assign memDone = MEM_HANDSHAKE ? mem_ready : 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (memDone) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (memDone) state_d = S_MEMWB;
      S_MEMWRITE: if (memDone) state_d = S_FETCH;
      S_MEMWB, S_ALUWB, S_BEQ:  state_d = S_FETCH;
      S_EXECR, S_EXECI, S_JAL:  state_d = S_ALUWB;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_TRAP;
    endcase
    illegal_d = illegal_q | (state_d == S_TRAP);
  end

  // funct7b5 only selects subtract for R-type; I-type addi shares the bit with the immediate.
  always_comb begin
    functAlu = ALU_ADD;
    case (funct3)
      3'b000:  functAlu = (funct7b5 && op[5]) ? ALU_SUB : ALU_ADD;
      3'b010:  functAlu = ALU_SLT;
      3'b110:  functAlu = ALU_OR;
      3'b111:  functAlu = ALU_AND;
      default: functAlu = ALU_ADD;
    endcase
  end

  // While reset is high the selects show FETCH values and every enable is held low.
  always_comb begin
    adr_src     = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_control = ALU_ADD;
    pcUpdate    = 1'b0;
    branch      = 1'b0;
    case (reset ? S_FETCH : state_q)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = memDone & ~reset;
        pcUpdate   = memDone & ~reset;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD:  adr_src = 1'b1;
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECR: begin
        alu_src_a   = 2'b10;
        alu_control = functAlu;
      end
      S_EXECI: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = functAlu;
      end
      S_ALUWB:    reg_write = 1'b1;
      S_BEQ: begin
        alu_src_a   = 2'b10;
        alu_control = ALU_SUB;
        branch      = 1'b1;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pcUpdate  = 1'b1;
      end
      default: ;
    endcase
    pc_write = pcUpdate | (branch & zero);
  end

  always_comb begin
    case (op)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  assign illegal = illegal_q;
  assign state_o = state_q;

endmodule
